// File: rtl/multi_square_object_pkg.sv
// Shared types and constants for the multi-object rectangle drawer.
package multi_square_object_pkg;

    localparam int OBJ_COORD_W = 11;
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    typedef struct packed {
        logic [OBJ_COORD_W-1:0] x;
        logic [OBJ_COORD_W-1:0] y;
        logic                   visible;
        logic                   blink;
    } obj_entry_t;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/object_bracket_cmp.sv
// Single-object inside test and offset computation (purely combinational).
// The bounds are compared one bit wider than the coordinates, so an object
// near the right/bottom screen edge does not wrap around to column/row 0.
module object_bracket_cmp #(
    parameter int COORD_W = 11,
    parameter int OBJ_W   = 32,
    parameter int OBJ_H   = 32
) (
    input  logic [COORD_W-1:0] pixel_x_i,
    input  logic [COORD_W-1:0] pixel_y_i,
    input  logic [COORD_W-1:0] obj_x_i,
    input  logic [COORD_W-1:0] obj_y_i,
    input  logic               en_i,
    output logic               hit_o,
    output logic [COORD_W-1:0] off_x_o,
    output logic [COORD_W-1:0] off_y_o
);

    logic [COORD_W:0] px_ext;
    logic [COORD_W:0] py_ext;
    logic [COORD_W:0] left_ext;
    logic [COORD_W:0] top_ext;
    logic [COORD_W:0] right_ext;
    logic [COORD_W:0] bottom_ext;

    assign px_ext     = {1'b0, pixel_x_i};
    assign py_ext     = {1'b0, pixel_y_i};
    assign left_ext   = {1'b0, obj_x_i};
    assign top_ext    = {1'b0, obj_y_i};
    assign right_ext  = left_ext + (COORD_W+1)'(OBJ_W);
    assign bottom_ext = top_ext + (COORD_W+1)'(OBJ_H);

    // Right and bottom edges are exclusive.
    assign hit_o = en_i
                && (px_ext >= left_ext) && (px_ext < right_ext)
                && (py_ext >= top_ext)  && (py_ext < bottom_ext);

    assign off_x_o = pixel_x_i - obj_x_i;
    assign off_y_o = pixel_y_i - obj_y_i;

endmodule

// File: rtl/multi_square_object.sv
// Draws NUM_OBJ same-size rectangles. Positions are double-buffered: writes
// land in a shadow set and are copied to the active set at frame start, so
// an object never tears mid-frame. Lowest index wins on overlap.
module multi_square_object
    import multi_square_object_pkg::*;
#(
    parameter int         NUM_OBJ      = 4,
    parameter int         COORD_W      = OBJ_COORD_W,
    parameter int         OBJ_W        = 32,
    parameter int         OBJ_H        = 32,
    parameter int         BLINK_FRAMES = 16,
    parameter logic [7:0] OBJECT_COLOR = 8'h5B,
    localparam int        IDX_W        = idx_width(NUM_OBJ)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               startOfFrame,
    input  logic               wrEn,
    input  logic [IDX_W-1:0]   wrIdx,
    input  logic [COORD_W-1:0] wrX,
    input  logic [COORD_W-1:0] wrY,
    input  logic               wrVisible,
    input  logic               wrBlink,
    output logic               drawingRequest,
    output logic [IDX_W-1:0]   hitIdx,
    output logic [COORD_W-1:0] offsetX,
    output logic [COORD_W-1:0] offsetY,
    output logic [7:0]         RGBout
);

    localparam int CNT_W = idx_width(BLINK_FRAMES);

    obj_entry_t           shadow_q [NUM_OBJ];
    obj_entry_t           active_q [NUM_OBJ];
    logic [CNT_W-1:0]     blink_cnt_q;
    logic                 blink_phase_q;

    logic [NUM_OBJ-1:0]   eff;
    logic [NUM_OBJ-1:0]   hit;
    logic [COORD_W-1:0]   off_x [NUM_OBJ];
    logic [COORD_W-1:0]   off_y [NUM_OBJ];

    logic                 draw_d;
    logic [IDX_W-1:0]     hit_idx_d;
    logic [COORD_W-1:0]   off_x_d;
    logic [COORD_W-1:0]   off_y_d;

    logic                 draw_q;
    logic [IDX_W-1:0]     hit_idx_q;
    logic [COORD_W-1:0]   off_x_q;
    logic [COORD_W-1:0]   off_y_q;
    logic [7:0]           rgb_q;

    // Shadow writes and frame-start copy; the copy sees the pre-write shadow.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wrEn && (32'(wrIdx) < NUM_OBJ)) begin
                shadow_q[wrIdx] <= '{x: wrX, y: wrY, visible: wrVisible, blink: wrBlink};
            end
            if (startOfFrame) begin
                active_q <= shadow_q;
            end
        end
    end

    // Frame counter for the shared blink phase.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (startOfFrame) begin
            if (32'(blink_cnt_q) == BLINK_FRAMES - 1) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q   <= blink_cnt_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
        assign eff[g] = active_q[g].visible && !(active_q[g].blink && blink_phase_q);

        object_bracket_cmp #(
            .COORD_W (COORD_W),
            .OBJ_W   (OBJ_W),
            .OBJ_H   (OBJ_H)
        ) u_cmp (
            .pixel_x_i (pixelX),
            .pixel_y_i (pixelY),
            .obj_x_i   (active_q[g].x),
            .obj_y_i   (active_q[g].y),
            .en_i      (eff[g]),
            .hit_o     (hit[g]),
            .off_x_o   (off_x[g]),
            .off_y_o   (off_y[g])
        );
    end

    // Priority encoder: scanning downwards lets the lowest hit index win.
    always_comb begin
        draw_d    = 1'b0;
        hit_idx_d = '0;
        off_x_d   = '0;
        off_y_d   = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                draw_d    = 1'b1;
                hit_idx_d = IDX_W'(i);
                off_x_d   = off_x[i];
                off_y_d   = off_y[i];
            end
        end
    end

    // One-cycle output register feeding the bitmap ROM and RGB mux.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            draw_q    <= 1'b0;
            hit_idx_q <= '0;
            off_x_q   <= '0;
            off_y_q   <= '0;
            rgb_q     <= TRANSPARENT_ENCODING;
        end else begin
            draw_q    <= draw_d;
            hit_idx_q <= hit_idx_d;
            off_x_q   <= off_x_d;
            off_y_q   <= off_y_d;
            rgb_q     <= draw_d ? OBJECT_COLOR : TRANSPARENT_ENCODING;
        end
    end

    assign drawingRequest = draw_q;
    assign hitIdx         = hit_idx_q;
    assign offsetX        = off_x_q;
    assign offsetY        = off_y_q;
    assign RGBout         = rgb_q;

endmodule

// File: tb/tb_multi_square_object.sv
// Bench for multi_square_object: a frame-level model predicts every output
// cycle; directed scenarios add hand-computed literal expectations.
module tb_multi_square_object;

    localparam int N  = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        wrEn = 1'b0;
    logic [1:0]  wrIdx = '0;
    logic [10:0] wrX = '0;
    logic [10:0] wrY = '0;
    logic        wrVisible = 1'b0;
    logic        wrBlink = 1'b0;
    logic        drawingRequest;
    logic [1:0]  hitIdx;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [7:0]  RGBout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    multi_square_object #(
        .NUM_OBJ      (N),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .startOfFrame   (startOfFrame),
        .wrEn           (wrEn),
        .wrIdx          (wrIdx),
        .wrX            (wrX),
        .wrY            (wrY),
        .wrVisible      (wrVisible),
        .wrBlink        (wrBlink),
        .drawingRequest (drawingRequest),
        .hitIdx         (hitIdx),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .RGBout         (RGBout)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int sx [N], sy [N], ax [N], ay [N];
    bit sv [N], sb [N], av [N], ab [N];
    int sof_n;
    int exp_dr, exp_idx, exp_ox, exp_oy, exp_rgb;

    function automatic void model_eval(input int px, input int py, input int phase,
                                       output int dr, output int idx,
                                       output int ox, output int oy);
        dr = 0; idx = 0; ox = 0; oy = 0;
        for (int i = 0; i < N; i++) begin
            if (dr == 0 && av[i] && !(ab[i] && phase == 1) &&
                px >= ax[i] && px < ax[i] + 32 && py >= ay[i] && py < ay[i] + 32) begin
                dr = 1; idx = i;
                ox = (px - ax[i]) & 2047;
                oy = (py - ay[i]) & 2047;
            end
        end
    endfunction

    always @(posedge clk or negedge resetN) begin
        int d, idx, ox, oy;
        if (!resetN) begin
            for (int i = 0; i < N; i++) begin
                sx[i] <= 0; sy[i] <= 0; sv[i] <= 0; sb[i] <= 0;
                ax[i] <= 0; ay[i] <= 0; av[i] <= 0; ab[i] <= 0;
            end
            sof_n <= 0;
            exp_dr <= 0; exp_idx <= 0; exp_ox <= 0; exp_oy <= 0; exp_rgb <= 'hFF;
        end else begin
            // Phase flips every BF frames since reset.
            model_eval(int'(pixelX), int'(pixelY), (sof_n / BF) % 2, d, idx, ox, oy);
            exp_dr  <= d;
            exp_idx <= idx;
            exp_ox  <= ox;
            exp_oy  <= oy;
            exp_rgb <= (d != 0) ? 'h5B : 'hFF;
            if (startOfFrame) begin
                for (int i = 0; i < N; i++) begin
                    ax[i] <= sx[i]; ay[i] <= sy[i]; av[i] <= sv[i]; ab[i] <= sb[i];
                end
                sof_n <= sof_n + 1;
            end
            if (wrEn && int'(wrIdx) < N) begin
                sx[wrIdx] <= int'(wrX);
                sy[wrIdx] <= int'(wrY);
                sv[wrIdx] <= wrVisible;
                sb[wrIdx] <= wrBlink;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && resetN) begin
            cmp("model.drawingRequest", int'(drawingRequest), exp_dr);
            cmp("model.hitIdx",         int'(hitIdx),         exp_idx);
            cmp("model.offsetX",        int'(offsetX),        exp_ox);
            cmp("model.offsetY",        int'(offsetY),        exp_oy);
            cmp("model.RGBout",         int'(RGBout),         exp_rgb);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int idx, input int x, input int y, input bit vis, input bit blk);
        wrEn = 1; wrIdx = 2'(idx); wrX = 11'(x); wrY = 11'(y); wrVisible = vis; wrBlink = blk;
        @(negedge clk);
        wrEn = 0;
    endtask

    task automatic sof();
        startOfFrame = 1;
        @(negedge clk);
        startOfFrame = 0;
    endtask

    // Drive a pixel; on return the outputs belong to that pixel.
    task automatic scan(input int x, input int y);
        pixelX = 11'(x); pixelY = 11'(y);
        @(negedge clk);
    endtask

    task automatic lit_hit(input string tag, input int idx, input int ox, input int oy);
        cmp({tag, ".drawingRequest"}, int'(drawingRequest), 1);
        cmp({tag, ".hitIdx"},         int'(hitIdx),         idx);
        cmp({tag, ".offsetX"},        int'(offsetX),        ox);
        cmp({tag, ".offsetY"},        int'(offsetY),        oy);
        cmp({tag, ".RGBout"},         int'(RGBout),         'h5B);
    endtask

    task automatic lit_miss(input string tag);
        cmp({tag, ".drawingRequest"}, int'(drawingRequest), 0);
        cmp({tag, ".RGBout"},         int'(RGBout),         'hFF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 0;
        @(negedge clk);
        resetN = 1;
    endtask

    int pat [5] = '{1, 0, 0, 1, 1};

    initial begin
        pixelX = 11'd1000; pixelY = 11'd1000;
        repeat (2) @(negedge clk);
        resetN = 1;
        chk_en = 1;
        @(negedge clk);
        lit_miss("reset");
        cmp("reset.hitIdx", int'(hitIdx), 0);
        cmp("reset.offsetX", int'(offsetX), 0);

        // 1: shadow write is invisible until frame start
        wr(0, 100, 50, 1, 0);
        scan(110, 60);
        lit_miss("t1.before_sof");
        sof();
        scan(110, 60);
        lit_hit("t1.after_sof", 0, 10, 10);

        // 2: inclusive left/top, exclusive right/bottom
        scan(131, 81);
        lit_hit("t2.corner", 0, 31, 31);
        scan(132, 60);
        lit_miss("t2.right_edge");
        scan(110, 82);
        lit_miss("t2.bottom_edge");

        // 3: overlap priority
        wr(0, 100, 50, 0, 0);
        wr(1, 100, 50, 1, 0);
        wr(3, 110, 60, 1, 0);
        sof();
        scan(115, 65);
        lit_hit("t3.ch1_wins", 1, 15, 15);
        wr(1, 100, 50, 0, 0);
        sof();
        scan(115, 65);
        lit_hit("t3.ch3_wins", 3, 5, 5);

        // 4: blink, phase counted from reset
        do_reset();
        wr(2, 200, 200, 1, 1);
        for (int k = 0; k < 5; k++) begin
            sof();
            scan(205, 205);
            cmp($sformatf("t4.blink_frame%0d", k + 1), int'(drawingRequest), pat[k]);
        end

        // 5: write coinciding with frame start is deferred one frame
        wr(0, 400, 400, 1, 0);
        sof();
        wrEn = 1; wrIdx = 2'd0; wrX = 11'd300; wrY = 11'd300; wrVisible = 1; wrBlink = 0;
        startOfFrame = 1;
        @(negedge clk);
        wrEn = 0; startOfFrame = 0;
        scan(405, 405);
        lit_hit("t5.old_pos", 0, 5, 5);
        scan(300, 300);
        lit_miss("t5.new_pos_early");
        sof();
        scan(300, 300);
        lit_hit("t5.new_pos", 0, 0, 0);

        // 6: right edge near the coordinate limit, then async reset
        wr(0, 2040, 0, 1, 0);
        sof();
        scan(2047, 5);
        lit_hit("t6.far_right", 0, 7, 5);
        scan(3, 5);
        lit_miss("t6.no_wrap");
        scan(2047, 5);
        #2 resetN = 0;
        #1;
        lit_miss("t6.async_reset");
        cmp("t6.async_reset.offsetX", int'(offsetX), 0);
        @(negedge clk);
        resetN = 1;
        scan(2047, 5);
        lit_miss("t6.after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
